// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: launcher states and
// the default byte width.
package uart_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } launch_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port, transmitter handshake and FIFO status of the UART
// transmit feeder. The feeder uses the slave view; its environment
// uses the master view.
interface uart_tx_feeder_if
   import uart_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              done_t;
   logic [DATA_W-1:0] tx_data;
   logic              tx_start;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              timeout_err;

   modport master (
      output wr_en, wr_data, done_t,
      input  tx_data, tx_start, full, empty, count, overflow, timeout_err
   );

   modport slave (
      input  wr_en, wr_data, done_t,
      output tx_data, tx_start, full, empty, count, overflow, timeout_err
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Small synchronous byte FIFO with registered occupancy flags and a
// one-cycle overflow pulse for writes dropped while full.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              overflow_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              overflow_q, overflow_d;
   logic              push, pop;

   // Acceptance uses the flags as they stood before the edge, so a push
   // while full is refused even if a pop frees a slot in the same cycle.
   assign push = wr_en_i && !full_q;
   assign pop  = rd_en_i && !empty_q;

   // Next pointers, occupancy and flags; pointers wrap because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d     = (count_d == CNT_W'(DEPTH));
      empty_d    = (count_d == '0);
      overflow_d = wr_en_i && full_q;
   end

   // Control state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   // Byte storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o  = mem_q[rd_ptr_q];
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch controller ahead of the UART transmitter: pops
// one byte at a time, pulses tx_start, then waits for done_t or a
// watchdog expiry before launching the next byte.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 20000
) (
   input logic               clk,
   input logic               rst,
   uart_tx_feeder_if.slave   bus_if
);

   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int WCNT_W = $clog2(TIMEOUT) + 1;

   launch_state_e     state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;
   logic              tout_q, tout_d;
   logic              pop;

   logic [DATA_W-1:0] fifo_rd_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_overflow;

   uart_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i      (clk),
      .rst_n_i    (rst),
      .wr_en_i    (bus_if.wr_en),
      .wr_data_i  (bus_if.wr_data),
      .rd_en_i    (pop),
      .rd_data_o  (fifo_rd_data),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count),
      .overflow_o (fifo_overflow)
   );

   // Launcher next state: tx_start is registered so it is high exactly
   // while the launcher sits in START; done_t outside WAIT is ignored.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      tout_d     = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               tx_data_d  = fifo_rd_data;
               tx_start_d = 1'b1;
               state_d    = START;
            end
         end
         START: begin
            wcnt_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus_if.done_t) begin
               state_d = IDLE;
            end else begin
               // Abandoned byte is counted as sent; it is not retried.
               wcnt_d = wcnt_q + 1'b1;
               if (wcnt_d == WCNT_W'(TIMEOUT - 1)) begin
                  tout_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Launcher state, watchdog counter and registered transmitter outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         tout_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         tout_q     <= tout_d;
      end
   end

   assign bus_if.tx_data     = tx_data_q;
   assign bus_if.tx_start    = tx_start_q;
   assign bus_if.full        = fifo_full;
   assign bus_if.empty       = fifo_empty;
   assign bus_if.count       = fifo_count;
   assign bus_if.overflow    = fifo_overflow;
   assign bus_if.timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: random and directed host writes, a transmitter
// stand-in answering tx_start with done_t, and a scoreboard monitor that
// compares every launch and status output against a queue-based model.
module tb_uart_tx_feeder;

   localparam int DW      = 8;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 50;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

   uart_tx_feeder #(
      .DATA_W  (DW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: bytes accepted but not yet launched, in launch order.
   logic [DW-1:0] exp_q[$];
   bit  outstanding = 1'b0;
   int  wait_cnt    = 0;
   bit  ovf_pending = 1'b0;
   int  resp_cnt    = -1;
   bit  resp_en     = 1'b1;
   int  resp_fixed  = 0;
   int  cyc         = 0;
   bit  lat_arm     = 1'b0;
   int  lat_edge    = 0;
   int  launches    = 0;
   int  timeouts    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // One host cycle: drive the write strobe and record the model's verdict.
   task automatic drive(input bit en, input logic [DW-1:0] d);
      @(negedge clk);
      bus.wr_en   = en;
      bus.wr_data = d;
      if (en && rst) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(d);
         else ovf_pending = 1'b1;
      end
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || outstanding) && k < budget) begin
         drive(1'b0, '0);
         k++;
      end
      check("drain", (exp_q.size() == 0 && !outstanding), 1);
   endtask

   // Transmitter stand-in: done_t a few cycles after each launch.
   initial begin
      bus.done_t = 1'b0;
      forever begin
         @(negedge clk);
         bus.done_t = 1'b0;
         if (resp_en && resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               bus.done_t = 1'b1;
               resp_cnt   = -1;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit exp_to;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (!rst) begin
            check("rst_tx_start", bus.tx_start, 0);
            check("rst_empty", bus.empty, 1);
            check("rst_count", bus.count, 0);
            check("rst_full", bus.full, 0);
            check("rst_overflow", bus.overflow, 0);
            check("rst_timeout", bus.timeout_err, 0);
            check("rst_tx_data", bus.tx_data, 0);
            exp_q.delete();
            outstanding = 1'b0;
            resp_cnt    = -1;
            ovf_pending = 1'b0;
         end else begin
            exp_to = 1'b0;
            if (outstanding) begin
               if (bus.done_t) begin
                  outstanding = 1'b0;
               end else begin
                  wait_cnt++;
                  if (wait_cnt == TIMEOUT) begin
                     exp_to      = 1'b1;
                     outstanding = 1'b0;
                     resp_cnt    = -1;
                     timeouts++;
                  end
               end
            end
            check("timeout_err", bus.timeout_err, exp_to);
            check("overflow", bus.overflow, ovf_pending);
            ovf_pending = 1'b0;
            if (bus.tx_start) begin
               check("launch_allowed", outstanding, 0);
               if (exp_q.size() == 0) check("unexpected_launch", bus.tx_start, 0);
               else check("tx_data", bus.tx_data, exp_q.pop_front());
               if (lat_arm) begin
                  check("first_latency", cyc, lat_edge + 1);
                  lat_arm = 1'b0;
               end
               outstanding = 1'b1;
               wait_cnt    = 0;
               launches++;
               resp_cnt = (resp_fixed != 0) ? resp_fixed : int'($urandom_range(3, 20));
            end
            check("count", bus.count, exp_q.size());
            check("full", bus.full, (exp_q.size() == DEPTH));
            check("empty", bus.empty, (exp_q.size() == 0));
         end
      end
   end

   // Stimulus.
   initial begin
      int l0, t0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;

      // Reset held with writes attempted.
      for (int i = 0; i < 3; i++) drive(1'b1, DW'($urandom));
      @(negedge clk);
      rst       = 1'b1;
      bus.wr_en = 1'b0;
      drive(1'b0, '0);

      // First byte: tx_start visible after the edge following the write edge.
      drive(1'b1, 8'h95);
      lat_edge = cyc + 1;
      lat_arm  = 1'b1;
      wait_drain(100);
      check("latency_seen", lat_arm, 0);

      // Burst 01..08 with fixed 10-cycle completion.
      resp_fixed = 10;
      l0 = launches;
      for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i));
      wait_drain(400);
      check("burst_launches", launches - l0, 8);
      resp_fixed = 0;

      // Overflow: no completions, fill to DEPTH, then one more write.
      resp_en = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() < DEPTH; i++) drive(1'b1, DW'(8'h10 + i));
      drive(1'b1, 8'hAA);
      drive(1'b0, '0);
      resp_en = 1'b1;
      wait_drain(1500);

      // Watchdog: two bytes, transmitter silent.
      resp_en = 1'b0;
      t0 = timeouts;
      drive(1'b1, 8'h55);
      drive(1'b1, 8'h66);
      wait_drain(300);
      check("timeouts_seen", timeouts - t0, 2);
      resp_en = 1'b1;

      // Reset while waiting with bytes queued.
      resp_en = 1'b0;
      for (int i = 0; i < 4; i++) drive(1'b1, DW'(8'hC0 + i));
      for (int i = 0; i < 5; i++) drive(1'b0, '0);
      rst = 1'b0;
      #1;
      check("async_tx_start", bus.tx_start, 0);
      check("async_count", bus.count, 0);
      check("async_empty", bus.empty, 1);
      check("async_tx_data", bus.tx_data, 0);
      exp_q.delete();
      outstanding = 1'b0;
      resp_cnt    = -1;
      for (int i = 0; i < 3; i++) drive(1'b0, '0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) drive(1'b0, '0);
      resp_en = 1'b1;
      l0 = launches;
      drive(1'b1, 8'h3C);
      wait_drain(100);
      check("post_reset_launch", launches - l0, 1);

      // Random traffic with random completion delays.
      for (int i = 0; i < 400; i++) drive($urandom_range(0, 9) < 4, DW'($urandom));
      wait_drain(600);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
